// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU constants for the M-extension unit: function codes plus small
// decode helpers used by the sequencer.
package muldiv_sequencer_pkg;

    // M-extension ALU function codes, routed from the ALU controller.
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    // True for any of the eight codes this unit implements.
    function automatic logic fn_known(input logic [4:0] fn);
        return fn inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Divide family (quotient or remainder).
    function automatic logic fn_is_div(input logic [4:0] fn);
        return fn inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Remainder results follow the dividend sign only.
    function automatic logic fn_is_rem(input logic [4:0] fn);
        return fn inside {ALU_REM, ALU_REMU};
    endfunction

    // Operand a is interpreted as signed.
    function automatic logic fn_signed_a(input logic [4:0] fn);
        return fn inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    // Operand b is interpreted as signed.
    function automatic logic fn_signed_b(input logic [4:0] fn);
        return fn inside {ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath. The accumulator holds
// {hi, lo}: for multiply hi is the partial product and lo the remaining
// multiplier bits; for divide hi is the partial remainder and lo collects
// quotient bits while shifting out dividend bits.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff;
    logic            rem_fits;

    // Shift-add multiply step or restoring-divide step, chosen by is_div_i.
    always_comb begin
        add_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        rem_fits  = (rem_shift >= {1'b0, operand_i});
        // When the divisor fits, the difference is below the divisor, so the
        // low XLEN bits hold it exactly.
        rem_diff  = rem_shift[XLEN-1:0] - operand_i;
        if (!is_div_i) begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end else if (rem_fits) begin
            acc_o = {rem_diff, acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: accepts one MUL/DIV/REM operation, runs 32
// iterations on magnitudes, applies sign correction and holds the result
// until the consumer takes it. Divide-by-zero, signed overflow and unknown
// codes bypass the iterations and answer on the cycle after accept.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge, and ready
// never depends combinationally on the same interface's valid.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_function,
    input  logic [XLEN-1:0] req_operand_a,
    input  logic [XLEN-1:0] req_operand_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    // FSM state for observation: 0 idle, 1 calc, 2 fixup, 3 done.
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_e;

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        func_q, func_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN-1:0] step_acc;
    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i  (fn_is_div(func_q)),
        .acc_i     (acc_q),
        .operand_i (opb_q),
        .acc_o     (step_acc)
    );

    assign req_ready   = (state_q == IDLE) && !flush;
    assign resp_valid  = (state_q == DONE);
    assign resp_result = result_q;
    assign dbg_state_o = state_q;
    assign accept      = req_valid && req_ready;

    // Next-state, operand capture, iteration and result selection.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        func_d   = func_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;

        a_neg    = req_operand_a[XLEN-1] & fn_signed_a(req_function);
        b_neg    = req_operand_b[XLEN-1] & fn_signed_b(req_function);
        abs_a    = a_neg ? -req_operand_a : req_operand_a;
        abs_b    = b_neg ? -req_operand_b : req_operand_b;
        div_zero = fn_is_div(req_function) && (req_operand_b == '0);
        div_ovf  = ((req_function == ALU_DIV) || (req_function == ALU_REM)) &&
                   (req_operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (req_operand_b == '1);

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    func_d  = req_function;
                    count_d = '0;
                    // Remainders take the dividend sign; everything else the
                    // product/quotient sign.
                    neg_d   = fn_is_rem(req_function) ? a_neg : (a_neg ^ b_neg);
                    acc_d   = {{XLEN{1'b0}}, abs_a};
                    opb_d   = abs_b;
                    if (!fn_known(req_function)) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (div_zero) begin
                        result_d = fn_is_rem(req_function) ? req_operand_a : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = fn_is_rem(req_function) ? '0 : req_operand_a;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(STEPS - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                case (func_q)
                    ALU_MUL:                         result_d = prod_fix[XLEN-1:0];
                    ALU_MULH, ALU_MULHSU, ALU_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    ALU_DIV, ALU_DIVU:               result_d = quo_fix;
                    ALU_REM, ALU_REMU:               result_d = rem_fix;
                    default:                         result_d = '0;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush kills whatever is in progress, including a held result.
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            func_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            func_q   <= func_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, flush/reset scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_function;
    logic [31:0] req_operand_a;
    logic [31:0] req_operand_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [1:0]  dbg_state_o;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  codes [8];

    muldiv_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_function  (req_function),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .dbg_state_o   (dbg_state_o)
    );

    // Clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [4:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              ia, ib, iq;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = 32'd0;
        case (fn)
            ALU_MUL:    begin p = sa * sb; r = p[31:0]; end
            ALU_MULH:   begin p = sa * sb; r = p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
            ALU_MULHU:  begin up = ua * ub; r = up[63:32]; end
            ALU_DIV: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin iq = ia / ib; r = iq; end
            end
            ALU_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin iq = ia % ib; r = iq; end
            end
            ALU_REMU: r = (b == 32'd0) ? a : a % b;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // Accept-to-valid latency in cycles, counting the accept cycle as 1.
    function automatic int exp_latency(input logic [4:0] fn, input logic [31:0] a,
                                       input logic [31:0] b);
        bit is_d = (fn == ALU_DIV || fn == ALU_DIVU || fn == ALU_REM || fn == ALU_REMU);
        bit ok   = is_d || fn == ALU_MUL || fn == ALU_MULH || fn == ALU_MULHSU || fn == ALU_MULHU;
        if (!ok) return 1;
        if (is_d && b == 32'd0) return 1;
        if ((fn == ALU_DIV || fn == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Driver: one request, optional response backpressure, then a response
    // handshake with a competing request that must not be accepted.
    task automatic do_op(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        int          lat;
        logic [31:0] got;
        exp_q.push_back(ref_model(fn, a, b));
        @(negedge clock);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_function  = fn;
        req_operand_a = a;
        req_operand_b = b;
        @(posedge clock);
        #1;
        req_valid     = 1'b0;
        req_operand_a = $urandom;
        req_operand_b = $urandom;
        req_function  = 5'($urandom_range(0, 31));
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", lat, exp_latency(fn, a, b));
        got = resp_result;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clock);
            #1;
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_result_stable", resp_result, got);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        check("result", got, exp_q.pop_front());
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("hs_resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("hs_state_idle", {30'd0, dbg_state_o}, 32'd0);
    endtask

    initial begin
        int          seen;
        logic [4:0]  fn;
        logic [31:0] a, b;
        int          sel;

        codes = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                  ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_function = 5'd0; req_operand_a = 32'd0; req_operand_b = 32'd0;

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_state", {30'd0, dbg_state_o}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed arithmetic cases.
        do_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 0);
        do_op(ALU_MULH,   32'h8000_0000,  32'h8000_0000, 0);
        do_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        do_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        do_op(ALU_DIV,    32'hFFFF_FFF9,  32'd2, 0);
        do_op(ALU_REM,    32'hFFFF_FFF9,  32'd2, 0);
        do_op(ALU_DIVU,   32'd100,        32'd7, 0);
        do_op(ALU_REMU,   32'd100,        32'd7, 0);
        do_op(ALU_DIVU,   32'd5,          32'd0, 0);
        do_op(ALU_REM,    32'd5,          32'd0, 0);
        do_op(ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0);
        do_op(ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0);
        do_op(5'd3,       32'd12,         32'd34, 0);

        // Backpressure in DONE for 10 cycles.
        do_op(ALU_MUL, 32'd1234, 32'd5678, 10);

        // Flush while idle with a request present: not accepted.
        @(negedge clock);
        flush = 1'b1; req_valid = 1'b1; req_function = ALU_MUL;
        #1;
        check("flush_idle_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle_state", {30'd0, dbg_state_o}, 32'd0);

        // Flush at CALC step 12 with a competing request.
        @(negedge clock);
        req_valid = 1'b1; req_function = ALU_DIV;
        req_operand_a = 32'd1000; req_operand_b = 32'd7;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("flush_calc_state", {30'd0, dbg_state_o}, 32'd1);
        @(negedge clock);
        flush = 1'b1; req_valid = 1'b1; req_function = ALU_DIVU;
        req_operand_a = 32'd9; req_operand_b = 32'd3;
        #1;
        check("flush_calc_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush_calc_to_idle", {30'd0, dbg_state_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (resp_valid === 1'b1) seen++;
        end
        check("flush_no_resp", seen, 32'd0);
        do_op(ALU_DIVU, 32'd9, 32'd3, 0);

        // Flush in DONE discards the held result.
        @(negedge clock);
        req_valid = 1'b1; req_function = ALU_DIVU;
        req_operand_a = 32'd5; req_operand_b = 32'd0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("flush_done_valid_pre", {31'd0, resp_valid}, 32'd1);
        @(negedge clock);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0; resp_ready = 1'b0;
        check("flush_done_valid", {31'd0, resp_valid}, 32'd0);
        check("flush_done_state", {30'd0, dbg_state_o}, 32'd0);

        // Reset mid-CALC returns to reset values immediately.
        @(negedge clock);
        req_valid = 1'b1; req_function = ALU_MULHU;
        req_operand_a = 32'hDEAD_BEEF; req_operand_b = 32'h1234_5678;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_resp_result", resp_result, 32'd0);
        check("midrst_state", {30'd0, dbg_state_o}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            fn  = codes[$urandom_range(0, 7)];
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(fn, a, b, $urandom_range(0, 3));
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
